// File: rtl/micro_seq_pkg.sv
// Shared sequencing-op encodings for the micro-sequencer and the microcode assembler tables.
package micro_seq_pkg;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] seq_op_t;

    localparam seq_op_t OP_CONT     = 3'd0;
    localparam seq_op_t OP_JUMP     = 3'd1;
    localparam seq_op_t OP_BRT      = 3'd2;
    localparam seq_op_t OP_BRF      = 3'd3;
    localparam seq_op_t OP_DISPATCH = 3'd4;
    localparam seq_op_t OP_CALL     = 3'd5;
    localparam seq_op_t OP_RET      = 3'd6;
    localparam seq_op_t OP_WAIT     = 3'd7;

    // WAIT holds the micro-PC until memory reports completion.
    function automatic logic is_stall(input seq_op_t op, input logic mem_ready);
        return (op == OP_WAIT) && !mem_ready;
    endfunction

endpackage

// File: rtl/micro_ret_stack.sv
// LIFO return-address stack for micro-subroutine CALL/RET; only the level pointer is reset.
module micro_ret_stack #(
    parameter int UADDR_W     = 8,
    parameter int STACK_DEPTH = 4,
    localparam int LVL_W      = $clog2(STACK_DEPTH + 1),
    localparam int IDX_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [UADDR_W-1:0] push_data,
    output logic [UADDR_W-1:0] top_data,
    output logic [LVL_W-1:0]   level,
    output logic               full,
    output logic               empty
);

    logic [UADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [LVL_W-1:0]   level_q;
    logic [LVL_W-1:0]   level_d;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;

    assign full     = (level_q == LVL_W'(STACK_DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign wr_idx   = IDX_W'(level_q);
    assign rd_idx   = IDX_W'(level_q - LVL_W'(1));
    assign top_data = mem_q[rd_idx];

    always_comb begin
        level_d = level_q;
        if (push && !full) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !empty) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // Entry storage carries no reset; stale entries are unreachable once the level drops.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microcode next-address sequencer: registered micro-PC with branch, dispatch, call/return and wait.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int                 UADDR_W     = 8,
    parameter int                 STACK_DEPTH = 4,
    parameter int                 NFLAGS      = 4,
    parameter logic [UADDR_W-1:0] RESET_ADDR  = '0,
    parameter logic [UADDR_W-1:0] TRAP_ADDR   = {UADDR_W{1'b1}},
    localparam int                FSEL_W      = (NFLAGS > 1) ? $clog2(NFLAGS) : 1,
    localparam int                LVL_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    seq_op,
    input  logic [UADDR_W-1:0] seq_target,
    input  logic [FSEL_W-1:0]  flag_sel,
    input  logic [NFLAGS-1:0]  flags,
    input  logic [UADDR_W-1:0] dispatch_addr,
    input  logic               mem_ready,
    output logic [UADDR_W-1:0] upc,
    output logic               stall,
    output logic               stack_err,
    output logic [LVL_W-1:0]   stack_level
);

    logic [UADDR_W-1:0] upc_q, upc_d;
    logic               err_q, err_d;
    logic [UADDR_W-1:0] upc_inc;
    logic [UADDR_W-1:0] stk_top;
    logic               stk_push, stk_pop, stk_full, stk_empty;
    logic               flag_bit;

    assign upc_inc   = upc_q + UADDR_W'(1);
    assign upc       = upc_q;
    assign stack_err = err_q;
    assign stall     = is_stall(seq_op, mem_ready);

    // Selectors beyond the implemented flags match no entry and read as 0.
    always_comb begin
        flag_bit = 1'b0;
        for (int i = 0; i < NFLAGS; i++) begin
            if (flag_sel == FSEL_W'(i)) flag_bit = flags[i];
        end
    end

    always_comb begin
        upc_d    = upc_q;
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        case (seq_op)
            OP_CONT:     upc_d = upc_inc;
            OP_JUMP:     upc_d = seq_target;
            OP_BRT:      upc_d = flag_bit ? seq_target : upc_inc;
            OP_BRF:      upc_d = flag_bit ? upc_inc : seq_target;
            OP_DISPATCH: upc_d = dispatch_addr;
            OP_CALL: begin
                if (stk_full) begin
                    upc_d = TRAP_ADDR;
                    err_d = 1'b1;
                end else begin
                    stk_push = 1'b1;
                    upc_d    = seq_target;
                end
            end
            OP_RET: begin
                if (stk_empty) begin
                    upc_d = TRAP_ADDR;
                    err_d = 1'b1;
                end else begin
                    stk_pop = 1'b1;
                    upc_d   = stk_top;
                end
            end
            OP_WAIT:     upc_d = mem_ready ? upc_inc : upc_q;
            default:     upc_d = upc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            upc_q <= RESET_ADDR;
            err_q <= 1'b0;
        end else begin
            upc_q <= upc_d;
            err_q <= err_d;
        end
    end

    micro_ret_stack #(
        .UADDR_W    (UADDR_W),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_ret_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (stk_push),
        .pop      (stk_pop),
        .push_data(upc_inc),
        .top_data (stk_top),
        .level    (stack_level),
        .full     (stk_full),
        .empty    (stk_empty)
    );

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed scenarios plus randomized ops against a queue-based reference model.
module tb_micro_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] seq_op;
    logic [7:0] seq_target;
    logic [1:0] flag_sel;
    logic [3:0] flags;
    logic [7:0] dispatch_addr;
    logic       mem_ready;
    logic [7:0] upc;
    logic       stall;
    logic       stack_err;
    logic [2:0] stack_level;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_upc;
    int m_stk[$];
    bit m_err;
    bit m_stall;
    logic obs_stall;

    always #5 clk = ~clk;

    micro_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .seq_op       (seq_op),
        .seq_target   (seq_target),
        .flag_sel     (flag_sel),
        .flags        (flags),
        .dispatch_addr(dispatch_addr),
        .mem_ready    (mem_ready),
        .upc          (upc),
        .stall        (stall),
        .stack_err    (stack_err),
        .stack_level  (stack_level)
    );

    // Apply one microword, sample stall before the edge, clock it, advance the model.
    task automatic step(input logic r, input logic [2:0] op, input logic [7:0] tgt,
                        input logic [1:0] fs, input logic [3:0] fl, input logic [7:0] da,
                        input logic rdy);
        int inc;
        bit fbit;
        reset = r; seq_op = op; seq_target = tgt; flag_sel = fs;
        flags = fl; dispatch_addr = da; mem_ready = rdy;
        #1;
        obs_stall = stall;
        m_stall = (op == 3'd7) && !rdy;
        @(posedge clk);
        #1;
        inc  = (m_upc + 1) % 256;
        fbit = (int'(fs) < 4) ? fl[fs] : 1'b0;
        if (r) begin
            m_upc = 0;
            m_stk.delete();
            m_err = 1'b0;
        end else begin
            case (op)
                3'd0: m_upc = inc;
                3'd1: m_upc = int'(tgt);
                3'd2: m_upc = fbit ? int'(tgt) : inc;
                3'd3: m_upc = fbit ? inc : int'(tgt);
                3'd4: m_upc = int'(da);
                3'd5: begin
                    if (m_stk.size() == 4) begin
                        m_upc = 255; m_err = 1'b1;
                    end else begin
                        m_stk.push_back(inc); m_upc = int'(tgt);
                    end
                end
                3'd6: begin
                    if (m_stk.size() == 0) begin
                        m_upc = 255; m_err = 1'b1;
                    end else begin
                        m_upc = m_stk.pop_back();
                    end
                end
                default: if (rdy) m_upc = inc;
            endcase
        end
    endtask

    task automatic test_reset();
        step(1'b1, 3'd5, 8'h33, 2'd0, 4'h0, 8'h00, 1'b1);
        checks++; if (upc !== 8'h00) begin errors++; $display("FAIL reset_upc got=%h exp=00", upc); end
        checks++; if (stack_level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", stack_level); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", stack_err); end
    endtask

    task automatic test_cont();
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 3'd0, 8'h00, 2'd0, 4'h0, 8'h00, 1'b0);
            checks++; if (upc !== 8'(i)) begin errors++; $display("FAIL cont_%0d got=%h exp=%h", i, upc, 8'(i)); end
        end
        step(1'b0, 3'd1, 8'hFF, 2'd0, 4'h0, 8'h00, 1'b0);
        checks++; if (upc !== 8'hFF) begin errors++; $display("FAIL jump_ff got=%h exp=ff", upc); end
        step(1'b0, 3'd0, 8'h00, 2'd0, 4'h0, 8'h00, 1'b0);
        checks++; if (upc !== 8'h00) begin errors++; $display("FAIL cont_wrap got=%h exp=00", upc); end
    endtask

    task automatic test_branch();
        step(1'b0, 3'd1, 8'h30, 2'd0, 4'h0, 8'h00, 1'b0);
        step(1'b0, 3'd2, 8'h40, 2'd2, 4'b0100, 8'h00, 1'b0);
        checks++; if (upc !== 8'h40) begin errors++; $display("FAIL brt_taken got=%h exp=40", upc); end
        step(1'b0, 3'd3, 8'h40, 2'd2, 4'b0100, 8'h00, 1'b0);
        checks++; if (upc !== 8'h41) begin errors++; $display("FAIL brf_not_taken got=%h exp=41", upc); end
        step(1'b0, 3'd2, 8'h60, 2'd1, 4'b0100, 8'h00, 1'b0);
        checks++; if (upc !== 8'h42) begin errors++; $display("FAIL brt_not_taken got=%h exp=42", upc); end
        step(1'b0, 3'd3, 8'h50, 2'd3, 4'b0100, 8'h00, 1'b0);
        checks++; if (upc !== 8'h50) begin errors++; $display("FAIL brf_taken got=%h exp=50", upc); end
        step(1'b0, 3'd4, 8'h12, 2'd0, 4'h0, 8'h77, 1'b0);
        checks++; if (upc !== 8'h77) begin errors++; $display("FAIL dispatch got=%h exp=77", upc); end
    endtask

    task automatic test_call_ret();
        step(1'b0, 3'd1, 8'h10, 2'd0, 4'h0, 8'h00, 1'b0);
        step(1'b0, 3'd5, 8'h80, 2'd0, 4'h0, 8'h00, 1'b0);
        checks++; if (upc !== 8'h80 || stack_level !== 3'd1) begin errors++; $display("FAIL call got upc=%h lvl=%0d exp upc=80 lvl=1", upc, stack_level); end
        step(1'b0, 3'd6, 8'h00, 2'd0, 4'h0, 8'h00, 1'b0);
        checks++; if (upc !== 8'h11 || stack_level !== 3'd0) begin errors++; $display("FAIL ret got upc=%h lvl=%0d exp upc=11 lvl=0", upc, stack_level); end
        step(1'b0, 3'd1, 8'hFF, 2'd0, 4'h0, 8'h00, 1'b0);
        step(1'b0, 3'd5, 8'h05, 2'd0, 4'h0, 8'h00, 1'b0);
        step(1'b0, 3'd6, 8'h00, 2'd0, 4'h0, 8'h00, 1'b0);
        checks++; if (upc !== 8'h00) begin errors++; $display("FAIL ret_wrap got=%h exp=00", upc); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_ret [4] = '{8'h31, 8'h21, 8'h11, 8'h01};
        step(1'b1, 3'd0, 8'h00, 2'd0, 4'h0, 8'h00, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 3'd5, 8'(16 * i), 2'd0, 4'h0, 8'h00, 1'b0);
            checks++; if (stack_level !== 3'(i) || upc !== 8'(16 * i)) begin errors++; $display("FAIL call_nest_%0d got upc=%h lvl=%0d", i, upc, stack_level); end
        end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL full_no_err got=%b exp=0", stack_err); end
        step(1'b0, 3'd5, 8'h99, 2'd0, 4'h0, 8'h00, 1'b0);
        checks++; if (upc !== 8'hFF || stack_level !== 3'd4 || stack_err !== 1'b1) begin errors++; $display("FAIL overflow got upc=%h lvl=%0d err=%b exp ff/4/1", upc, stack_level, stack_err); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 3'd6, 8'h00, 2'd0, 4'h0, 8'h00, 1'b0);
            checks++; if (upc !== exp_ret[i] || stack_err !== 1'b1) begin errors++; $display("FAIL unwind_%0d got upc=%h err=%b exp upc=%h err=1", i, upc, stack_err, exp_ret[i]); end
        end
    endtask

    task automatic test_underflow();
        step(1'b1, 3'd0, 8'h00, 2'd0, 4'h0, 8'h00, 1'b0);
        step(1'b0, 3'd6, 8'h00, 2'd0, 4'h0, 8'h00, 1'b0);
        checks++; if (upc !== 8'hFF || stack_err !== 1'b1 || stack_level !== 3'd0) begin errors++; $display("FAIL underflow got upc=%h err=%b lvl=%0d exp ff/1/0", upc, stack_err, stack_level); end
        step(1'b0, 3'd0, 8'h00, 2'd0, 4'h0, 8'h00, 1'b0);
        checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", stack_err); end
    endtask

    task automatic test_wait();
        step(1'b0, 3'd1, 8'h20, 2'd0, 4'h0, 8'h00, 1'b0);
        checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL stall_jump got=%b exp=0", obs_stall); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'd7, 8'h00, 2'd0, 4'h0, 8'h00, 1'b0);
            checks++; if (obs_stall !== 1'b1 || upc !== 8'h20) begin errors++; $display("FAIL wait_hold_%0d got stall=%b upc=%h exp 1/20", i, obs_stall, upc); end
        end
        step(1'b0, 3'd7, 8'h00, 2'd0, 4'h0, 8'h00, 1'b1);
        checks++; if (obs_stall !== 1'b0 || upc !== 8'h21) begin errors++; $display("FAIL wait_done got stall=%b upc=%h exp 0/21", obs_stall, upc); end
    endtask

    task automatic test_reset_during_wait();
        step(1'b1, 3'd0, 8'h00, 2'd0, 4'h0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 3'd5, 8'h10, 2'd0, 4'h0, 8'h00, 1'b0);
        step(1'b0, 3'd6, 8'h00, 2'd0, 4'h0, 8'h00, 1'b0);
        step(1'b0, 3'd6, 8'h00, 2'd0, 4'h0, 8'h00, 1'b0);
        step(1'b0, 3'd7, 8'h00, 2'd0, 4'h0, 8'h00, 1'b0);
        checks++; if (stack_level !== 3'd2 || stack_err !== 1'b1) begin errors++; $display("FAIL pre_reset got lvl=%0d err=%b exp 2/1", stack_level, stack_err); end
        step(1'b1, 3'd7, 8'h00, 2'd0, 4'h0, 8'h00, 1'b0);
        checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL stall_in_reset got=%b exp=1", obs_stall); end
        checks++; if (upc !== 8'h00 || stack_level !== 3'd0 || stack_err !== 1'b0) begin errors++; $display("FAIL reset_wait got upc=%h lvl=%0d err=%b exp 00/0/0", upc, stack_level, stack_err); end
    endtask

    task automatic test_random();
        step(1'b1, 3'd0, 8'h00, 2'd0, 4'h0, 8'h00, 1'b0);
        for (int n = 0; n < 500; n++) begin
            step(($urandom_range(0, 59) == 0), 3'($urandom), 8'($urandom), 2'($urandom),
                 4'($urandom), 8'($urandom), 1'($urandom));
            checks++;
            if (upc !== 8'(m_upc) || stack_level !== 3'(m_stk.size()) ||
                stack_err !== m_err || obs_stall !== m_stall) begin
                errors++;
                $display("FAIL random_%0d got upc=%h lvl=%0d err=%b stall=%b exp upc=%h lvl=%0d err=%b stall=%b",
                         n, upc, stack_level, stack_err, obs_stall, 8'(m_upc), m_stk.size(), m_err, m_stall);
            end
        end
    endtask

    initial begin
        m_upc = 0; m_err = 1'b0; m_stall = 1'b0;
        test_reset();
        test_cont();
        test_branch();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_wait();
        test_reset_during_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
